aes_pipe_hs: RTL and testbench
==============================

Name: aes_pipe_hs

Overview:
Parametrised, fully pipelined AES-128 encryptor with valid/ready handshakes on both sides, per-block valid tracking, a sideband tag and an optional CTR-style output XOR. Successor to the free-running fixed 10-stage encryptor. Any block may use a new key, and throughput is one block per cycle when not back-pressured. Built from the team's existing round primitives: addRoundKey, keyExpansion with rcon index, encryptRound and lastEncryptRound.

Parameters:
RPS, 1, AES rounds per pipeline stage. Legal values: 1, 2, 5, 10. STAGES = 10/RPS. Other values are a compile-time error.
TAG_W, 4, width of the sideband tag carried alongside each block.
XOR_D, 0, 1: C = AES(K,P) ^ D. 0: C = AES(K,P), D ignored and not stored.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  P/K/D/in_tag valid
in_ready  out  1  block accepted on an edge where in_valid && in_ready
P  in  128  plaintext (or counter block in CTR use)
K  in  128  cipher key for this block
D  in  128  data XORed into result when XOR_D=1
in_tag  in  TAG_W  user tag, returned with result
out_valid  out  1  C/out_tag valid
out_ready  in  1  consumer accepts on an edge where out_valid && out_ready
C  out  128  ciphertext / keystream-XORed data
out_tag  out  TAG_W  tag of block on C
busy  out  1  OR of all stage valid bits

Behaviour:
- Reset (async, immediate): all stage valid bits = 0, out_valid = 0, C = 0, out_tag = 0, busy = 0. All stage state, key, D and tag registers = 0.
- Pipeline registers S0..S_STAGES. Each stage holds valid, state[127:0], roundkey[127:0], next rcon index, D (only if XOR_D), and tag. S_STAGES drives C, out_tag and out_valid.
- S0 load: state = P ^ K, roundkey = K, rcon index = 1.
- Stage s (1..STAGES) combinationally applies RPS rounds to S(s-1). For each round r: keyExpansion(prev key, r), then encryptRound with the expanded key. Round 10 uses lastEncryptRound (no MixColumns). The round key is chained within a stage.
- Final stage: C = result ^ D when XOR_D=1, else result.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, combinational; it must not depend on in_valid.
- When adv = 1, every register Si takes S(i-1), and S0 takes the input with valid = in_valid. When adv = 0, all stages hold.
- Bubbles are not collapsed. Invalid slots advance like valid ones.
- Latency: a block accepted at edge t appears with out_valid = 1 after edge t+STAGES when no stall occurs (10 cycles for RPS=1, 1 cycle for RPS=10). Each stalled cycle adds exactly one cycle.
- Throughput: 1 block/cycle while out_ready = 1.
- Ordering: strictly FIFO. Tags return in acceptance order.
- Output stability: while out_valid && !out_ready, C and out_tag are held unchanged.
- Simultaneous accept + emit on the same edge with a full pipe: allowed; there is no loss and no duplication.
- in_valid = 0 with adv = 1 inserts a bubble.
- Reset mid-operation: all in-flight blocks are discarded. After reset release, the first accepted block follows normal latency.
- Key change per block is legal; each block uses only its own K.

Test Plan:
- RPS=1, XOR_D=0, single block: K=000102030405060708090a0b0c0d0e0f, P=00112233445566778899aabbccddeeff, tag=3 -> out_valid exactly 10 cycles after accept, C=69c4e0d86a7b0430d8cdb78070b4c55a, out_tag=3.
- Back-to-back streaming, RPS=2, out_ready=1: alternate the key above with K=2b7e151628aed2a6abf7158809cf4f3c, P=3243f6a8885a308d313198a2e0370734, 20 blocks, tags 0..19 -> C alternates 69c4…c55a / 3925841d02dc09fbdc118597196a0b32, tags in order, one output per cycle after 5-cycle fill.
- Backpressure, RPS=1: stream 12 blocks, drop out_ready for 7 cycles mid-stream -> in_ready=0 for exactly those cycles, C/out_tag held constant, no block lost or duplicated, total count 12.
- XOR_D=1, FIPS vector 1 with D=all ones -> C=963b1f279584fbcf2732487f8f4b3aa5. Repeat with D=0 -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- RPS=10 and RPS=5: vector 2 -> latency 1 and 2 cycles respectively, same C 3925841d02dc09fbdc118597196a0b32.
- Reset mid-stream: assert rst asynchronously with 6 blocks in flight -> out_valid=0, C=0 and busy=0 immediately. The next block after release completes with correct C and normal latency, and no stale output appears.

Source files
------------

// File: rtl/aes_pipe_hs.sv
// Fully pipelined AES-128 encryptor with valid/ready handshakes, a per-block key,
// a sideband tag and an optional output XOR. RPS rounds per stage, 10/RPS stages.
module aes_pipe_hs #(
  parameter int RPS   = 1,
  parameter int TAG_W = 4,
  parameter int XOR_D = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     P,
  input  logic [127:0]     K,
  input  logic [127:0]     D,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     C,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int STAGES = 10 / RPS;

  if (!(RPS == 1 || RPS == 2 || RPS == 5 || RPS == 10)) begin : g_bad_rps
    $error("aes_pipe_hs: RPS must be 1, 2, 5 or 10");
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = b;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expansion(input logic [127:0] k, input logic [3:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {w3[23:0], w3[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon(rc), 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte n of the state sits at [127-8n -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] encrypt_round(input logic [127:0] s, input logic [127:0] rk);
    return mix_columns(sub_shift(s)) ^ rk;
  endfunction

  function automatic logic [127:0] last_encrypt_round(input logic [127:0] s, input logic [127:0] rk);
    return sub_shift(s) ^ rk;
  endfunction

  function automatic void run_stage(input logic [127:0] st_i, input logic [127:0] key_i,
                                    input logic [3:0] rc_i,
                                    output logic [127:0] st_o, output logic [127:0] key_o);
    logic [3:0] rc;
    st_o  = st_i;
    key_o = key_i;
    for (int j = 0; j < RPS; j++) begin
      rc    = rc_i + 4'(j);
      key_o = key_expansion(key_o, rc);
      st_o  = (rc == 4'd10) ? last_encrypt_round(st_o, key_o) : encrypt_round(st_o, key_o);
    end
  endfunction

  logic [STAGES:0]   valid_q, valid_d;
  logic [127:0]      state_q [0:STAGES];
  logic [127:0]      state_d [0:STAGES];
  logic [127:0]      key_q   [0:STAGES];
  logic [127:0]      key_d   [0:STAGES];
  logic [3:0]        rcon_q  [0:STAGES];
  logic [3:0]        rcon_d  [0:STAGES];
  logic [127:0]      d_q     [0:STAGES];
  logic [127:0]      d_d     [0:STAGES];
  logic [TAG_W-1:0]  tag_q   [0:STAGES];
  logic [TAG_W-1:0]  tag_d   [0:STAGES];
  logic [127:0]      rnd_state [1:STAGES];
  logic [127:0]      rnd_key   [1:STAGES];
  logic              adv;

  assign adv = !valid_q[STAGES] || out_ready;

  always_comb begin
    for (int s = 1; s <= STAGES; s++)
      run_stage(state_q[s-1], key_q[s-1], rcon_q[s-1], rnd_state[s], rnd_key[s]);
  end

  // The whole pipe moves as one shift register; bubbles advance like valid slots.
  always_comb begin
    valid_d = valid_q;
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    d_d     = d_q;
    tag_d   = tag_q;
    if (adv) begin
      valid_d[0] = in_valid;
      state_d[0] = P ^ K;
      key_d[0]   = K;
      rcon_d[0]  = 4'd1;
      d_d[0]     = (XOR_D != 0) ? D : '0;
      tag_d[0]   = in_tag;
      for (int s = 1; s <= STAGES; s++) begin
        valid_d[s] = valid_q[s-1];
        state_d[s] = rnd_state[s] ^ ((s == STAGES && XOR_D != 0) ? d_q[s-1] : '0);
        key_d[s]   = rnd_key[s];
        rcon_d[s]  = rcon_q[s-1] + 4'(RPS);
        d_d[s]     = d_q[s-1];
        tag_d[s]   = tag_q[s-1];
      end
    end
  end

  // NOTE: the data arrays are reset too, not only the valid bits, so C and out_tag read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s <= STAGES; s++) begin
        state_q[s] <= '0;
        key_q[s]   <= '0;
        rcon_q[s]  <= '0;
        d_q[s]     <= '0;
        tag_q[s]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      d_q     <= d_d;
      tag_q   <= tag_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = valid_q[STAGES];
  assign C         = state_q[STAGES];
  assign out_tag   = tag_q[STAGES];
  assign busy      = |valid_q;

endmodule

// File: tb/tb_aes_pipe_hs.sv
// Directed bench for aes_pipe_hs: five instances (RPS 1/2/1+XOR/10/5) share one stimulus
// stream; single-block vectors come from a table, streaming/stall/reset cases are hand-written.
module tb_aes_pipe_hs;
  localparam int N = 5;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] d;
    logic [127:0] exp_aes;
    logic [127:0] exp_xor;
    logic [4:0]   tag;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] p_i = '0, k_i = '0, d_i = '0;
  logic [4:0]   tag_i = '0;

  wire  [N-1:0] ov, ir, bz;
  wire  [127:0] c_o  [N];
  wire  [4:0]   tg_o [N];

  int n_cmp = 0;
  int n_err = 0;
  vec_t vt[4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int G_RPS = (g == 1) ? 2 : (g == 3) ? 10 : (g == 4) ? 5 : 1;
    localparam int G_XOR = (g == 2) ? 1 : 0;
    aes_pipe_hs #(.RPS(G_RPS), .TAG_W(5), .XOR_D(G_XOR)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[g]),
      .P(p_i), .K(k_i), .D(d_i), .in_tag(tag_i),
      .out_valid(ov[g]), .out_ready(out_ready), .C(c_o[g]), .out_tag(tg_o[g]), .busy(bz[g])
    );
  end

  function automatic int lat_of(input int g);
    return (g == 1) ? 5 : (g == 3) ? 1 : (g == 4) ? 2 : 10;
  endfunction

  function automatic vec_t mk(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] d,
                              input logic [127:0] ea, input logic [127:0] ex, input logic [4:0] tag);
    vec_t v;
    v.key = key; v.pt = pt; v.d = d; v.exp_aes = ea; v.exp_xor = ex; v.tag = tag;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic drive(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] d,
                       input logic [4:0] tag);
    in_valid = 1'b1; k_i = key; p_i = pt; d_i = d; tag_i = tag;
  endtask

  // One block into every instance; record the first cycle each out_valid rises.
  task automatic run_single(input vec_t v, input string nm);
    int           first [N];
    logic [127:0] cap_c [N];
    logic [4:0]   cap_t [N];
    for (int g = 0; g < N; g++) begin
      first[g] = -1; cap_c[g] = '0; cap_t[g] = '0;
    end
    @(negedge clk);
    out_ready = 1'b1;
    drive(v.key, v.pt, v.d, v.tag);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < N; g++)
        if (ov[g] && first[g] < 0) begin
          first[g] = k; cap_c[g] = c_o[g]; cap_t[g] = tg_o[g];
        end
    end
    for (int g = 0; g < N; g++) begin
      check($sformatf("%s_lat_g%0d", nm, g), 128'(first[g]), 128'(lat_of(g)));
      check($sformatf("%s_c_g%0d", nm, g), cap_c[g], (g == 2) ? v.exp_xor : v.exp_aes);
      check($sformatf("%s_tag_g%0d", nm, g), 128'(cap_t[g]), 128'(v.tag));
    end
  endtask

  function automatic logic [127:0] exp_alt(input int n);
    return (n % 2 == 1) ? C2 : C1;
  endfunction

  initial begin
    int n_out, i_in;
    logic [127:0] held_c;
    logic [4:0]   held_t;

    vt[0] = mk(K1, P1, '1, C1, 128'h963b1f279584fbcf2732487f8f4b3aa5, 5'd3);
    vt[1] = mk(K1, P1, '0, C1, C1, 5'd4);
    vt[2] = mk(K2, P2, '0, C2, C2, 5'd5);
    vt[3] = mk(K2, P2, '1, C2, 128'hc6da7be2fd23f60423ee7a68e695f4cd, 5'd6);

    #1;
    for (int g = 0; g < N; g++) begin
      check($sformatf("rst_ov_g%0d", g), 128'(ov[g]), 128'(0));
      check($sformatf("rst_c_g%0d", g), c_o[g], '0);
      check($sformatf("rst_busy_g%0d", g), 128'(bz[g]), 128'(0));
      check($sformatf("rst_ready_g%0d", g), 128'(ir[g]), 128'(1));
    end
    do_reset();

    for (int i = 0; i < 4; i++) run_single(vt[i], $sformatf("vec%0d", i));

    // Back-to-back stream on the RPS=2 instance, alternating keys.
    do_reset();
    n_out = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc < 20) drive((cyc % 2 == 1) ? K2 : K1, (cyc % 2 == 1) ? P2 : P1, '0, 5'(cyc));
      else in_valid = 1'b0;
      @(posedge clk);
      #1;
      if (ov[1]) begin
        check($sformatf("strm_slot%0d", n_out), 128'(cyc), 128'(n_out + 5));
        check($sformatf("strm_tag%0d", n_out), 128'(tg_o[1]), 128'(n_out));
        check($sformatf("strm_c%0d", n_out), c_o[1], exp_alt(n_out));
        n_out++;
      end
    end
    check("strm_count", 128'(n_out), 128'(20));

    // Backpressure on the RPS=1 instance: out_ready low for cycles 11..17.
    do_reset();
    n_out = 0; i_in = 0; held_c = '0; held_t = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 11 && cyc <= 17);
      if (i_in < 12) drive((i_in % 2 == 1) ? K2 : K1, (i_in % 2 == 1) ? P2 : P1, '0, 5'(i_in));
      else in_valid = 1'b0;
      #1;
      if (cyc < 30) check($sformatf("bp_ready_c%0d", cyc), 128'(ir[0]), 128'(out_ready));
      if (cyc == 11) begin
        held_c = c_o[0]; held_t = tg_o[0];
      end
      if (cyc > 11 && cyc <= 17) begin
        check($sformatf("bp_hold_c%0d", cyc), c_o[0], held_c);
        check($sformatf("bp_hold_tag%0d", cyc), 128'(tg_o[0]), 128'(held_t));
      end
      if (ov[0] && out_ready) begin
        check($sformatf("bp_tag%0d", n_out), 128'(tg_o[0]), 128'(n_out));
        check($sformatf("bp_c%0d", n_out), c_o[0], exp_alt(n_out));
        n_out++;
      end
      if (in_valid && ir[0]) i_in++;
      @(posedge clk);
    end
    check("bp_out_count", 128'(n_out), 128'(12));
    check("bp_in_count", 128'(i_in), 128'(12));

    // Asynchronous reset with six blocks in flight, then one fresh block.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive((i % 2 == 1) ? K2 : K1, (i % 2 == 1) ? P2 : P1, '0, 5'(i + 10));
      @(posedge clk);
    end
    #3 in_valid = 1'b0;
    check("mrst_busy_before", 128'(bz[0]), 128'(1));
    rst = 1'b1;
    #1;
    check("mrst_ov", 128'(ov[0]), 128'(0));
    check("mrst_c", c_o[0], '0);
    check("mrst_tag", 128'(tg_o[0]), 128'(0));
    check("mrst_busy", 128'(bz[0]), 128'(0));
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    run_single(vt[2], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
